// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DW        = 8;
  localparam int DEF_MAX_BURST = 4;

  // Index width that stays legal when a count of one is requested.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr_i, wrapping.
module rr_picker import fifo_arb_pkg::*; #(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic [IW-1:0]    index_o,
  output logic             valid_o
);

  int j;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    index_o = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(rr_ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[IW'(j)]) begin
        index_o = IW'(j);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging N_REQ producers into one FIFO write port.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DW        = DEF_DW,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IW        = idx_w(N_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data_in,
  input  logic [N_REQ-1:0]    last,
  input  logic                fifo_full,
  output logic [N_REQ-1:0]    gnt,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_data,
  output logic [IW-1:0]       owner,
  output logic                busy
);

  localparam int CW = idx_w(MAX_BURST);

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            last_beat;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .index_o  (pick_idx),
    .valid_o  (pick_vld)
  );

  // Beat acceptance is combinational so a write lands in the same cycle as its grant.
  always_comb begin
    gnt = '0;
    if (!reset && state_q == BURST && req[owner_q] && !fifo_full) gnt[owner_q] = 1'b1;
  end

  assign fifo_wr_en = |gnt;
  assign fifo_data  = fifo_wr_en ? data_in[int'(owner_q)*DW +: DW] : '0;
  assign busy       = (state_q == BURST) && !reset;
  assign owner      = reset ? '0 : owner_q;
  assign rr_ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign last_beat  = last[owner_q] || (beat_cnt_q == CW'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q    <= BURST;
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        BURST: begin
          // A dropped request aborts; a full FIFO simply freezes everything.
          if (!req[owner_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= rr_ptr_d;
          end else if (fifo_wr_en) begin
            if (last_beat) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  ap_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  ap_wr_not_full: assert property (@(posedge clk) disable iff (reset) fifo_wr_en |-> !fifo_full);
  ap_owner_stable: assert property (@(posedge clk) disable iff (reset)
    (state_q == BURST) |=> (state_q == IDLE || $stable(owner_q)));
  ap_cnt_range: assert property (@(posedge clk) disable iff (reset) int'(beat_cnt_q) < MAX_BURST);

endmodule
